// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb placement path: tile states, wall codes and player ids.
package bomb_pkg;

  localparam int unsigned GRID_W  = 16;
  localparam int unsigned N_TILES = 256;

  typedef enum logic [2:0] {
    EMPTY,
    READY_EXP,
    BOMB_UN,
    EXP_UP,
    EXP_DOWN,
    EXP_LEFT,
    EXP_RIGHT,
    EXP_CEN
  } tile_state_e;

  typedef enum logic [1:0] {
    EMPTY_WALL  = 2'd0,
    ABLE_WALL   = 2'd1,
    UNABLE_WALL = 2'd2
  } wall_e;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_e;

endpackage

// File: rtl/bomb_slot_bank.sv
// Per-player live-bomb capacity tracker: hold counters, lowest-free-slot allocation and popcount.
module bomb_slot_bank
  import bomb_pkg::*;
#(
  parameter int unsigned SlotHold = 61,
  parameter int unsigned MaxSlots = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       grant_i,
  input  logic [2:0] cap_i,
  output logic       full_o,
  output logic [2:0] count_o
);

  localparam int unsigned CntW = $clog2(SlotHold);

  logic [MaxSlots-1:0] occ_q, occ_d;
  logic [CntW-1:0]     cnt_q [MaxSlots];
  logic [CntW-1:0]     cnt_d [MaxSlots];
  logic [MaxSlots-1:0] expire, free_now, alloc_oh;
  logic [2:0]          eff_cap, live, occ_cnt;
  logic                found;

  always_comb begin
    live    = '0;
    occ_cnt = '0;
    for (int i = 0; i < MaxSlots; i++) begin
      expire[i]   = occ_q[i] && (cnt_q[i] == CntW'(SlotHold - 1));
      free_now[i] = !occ_q[i] || expire[i];
      live        = live + {2'b00, occ_q[i] & ~expire[i]};
      occ_cnt     = occ_cnt + {2'b00, occ_q[i]};
    end

    if (cap_i == 3'd0) begin
      eff_cap = 3'd1;
    end else if (cap_i > 3'(MaxSlots)) begin
      eff_cap = 3'(MaxSlots);
    end else begin
      eff_cap = cap_i;
    end
    // A slot expiring this cycle already counts as free for a request seen this cycle.
    full_o  = (live >= eff_cap);
    count_o = occ_cnt;

    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < MaxSlots; i++) begin
      if (free_now[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end

    for (int i = 0; i < MaxSlots; i++) begin
      occ_d[i] = occ_q[i] & ~expire[i];
      cnt_d[i] = (occ_q[i] && !expire[i]) ? cnt_q[i] + CntW'(1) : '0;
      if (grant_i && alloc_oh[i]) begin
        occ_d[i] = 1'b1;
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
      for (int i = 0; i < MaxSlots; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < MaxSlots; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/bomb_put_ctrl.sv
// Turns both players' place-key levels into legal, contention-resolved one-cycle put/deny pulses.
module bomb_put_ctrl
  import bomb_pkg::*;
#(
  parameter int unsigned SlotHold = 61,
  parameter int unsigned MaxSlots = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   game_run_i,
  input  logic                   p1_key_i,
  input  logic                   p2_key_i,
  input  logic [7:0]             p1_cor_i,
  input  logic [7:0]             p2_cor_i,
  input  logic [2:0]             p1_cap_i,
  input  logic [2:0]             p2_cap_i,
  input  logic [2*N_TILES-1:0]   wall_grid_i,
  input  logic [N_TILES-1:0]     bomb_un_grid_i,
  input  logic [N_TILES-1:0]     explode_i,
  output logic                   p1_put_o,
  output logic                   p2_put_o,
  output logic                   p1_deny_o,
  output logic                   p2_deny_o,
  output logic [2:0]             bomb_num_p1_o,
  output logic [2:0]             bomb_num_p2_o
);

  logic       p1_key_q, p2_key_q;
  logic       p1_put_q, p1_put_d, p2_put_q, p2_put_d;
  logic       p1_deny_q, p1_deny_d, p2_deny_q, p2_deny_d;
  player_e    prio_q, prio_d;
  logic [7:0] last1_q, last2_q;
  logic       last1_vld_q, last2_vld_q;
  logic       req1, req2, legal1, legal2, hit1, hit2, p1_full, p2_full;
  wall_e      wall1, wall2;

  always_comb begin
    req1  = p1_key_i & ~p1_key_q;
    req2  = p2_key_i & ~p2_key_q;
    wall1 = wall_e'(wall_grid_i[{p1_cor_i, 1'b0} +: 2]);
    wall2 = wall_e'(wall_grid_i[{p2_cor_i, 1'b0} +: 2]);
    // The datapath shows a fresh bomb one cycle late, so last cycle's grants also block a tile.
    hit1  = (last1_vld_q && last1_q == p1_cor_i) || (last2_vld_q && last2_q == p1_cor_i);
    hit2  = (last1_vld_q && last1_q == p2_cor_i) || (last2_vld_q && last2_q == p2_cor_i);
    legal1 = game_run_i && (wall1 == EMPTY_WALL) && !bomb_un_grid_i[p1_cor_i] &&
             !explode_i[p1_cor_i] && !hit1 && !p1_full;
    legal2 = game_run_i && (wall2 == EMPTY_WALL) && !bomb_un_grid_i[p2_cor_i] &&
             !explode_i[p2_cor_i] && !hit2 && !p2_full;

    p1_put_d = req1 && legal1;
    p2_put_d = req2 && legal2;
    prio_d   = prio_q;
    if (p1_put_d && p2_put_d && (p1_cor_i == p2_cor_i)) begin
      if (prio_q == P1) begin
        p2_put_d = 1'b0;
        prio_d   = P2;
      end else begin
        p1_put_d = 1'b0;
        prio_d   = P1;
      end
    end
    p1_deny_d = game_run_i && req1 && !p1_put_d;
    p2_deny_d = game_run_i && req2 && !p2_put_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p1_key_q    <= 1'b0;
      p2_key_q    <= 1'b0;
      p1_put_q    <= 1'b0;
      p2_put_q    <= 1'b0;
      p1_deny_q   <= 1'b0;
      p2_deny_q   <= 1'b0;
      prio_q      <= P1;
      last1_q     <= '0;
      last2_q     <= '0;
      last1_vld_q <= 1'b0;
      last2_vld_q <= 1'b0;
    end else begin
      p1_key_q    <= p1_key_i;
      p2_key_q    <= p2_key_i;
      p1_put_q    <= p1_put_d;
      p2_put_q    <= p2_put_d;
      p1_deny_q   <= p1_deny_d;
      p2_deny_q   <= p2_deny_d;
      prio_q      <= prio_d;
      last1_q     <= p1_cor_i;
      last2_q     <= p2_cor_i;
      last1_vld_q <= p1_put_d;
      last2_vld_q <= p2_put_d;
    end
  end

  assign p1_put_o  = p1_put_q;
  assign p2_put_o  = p2_put_q;
  assign p1_deny_o = p1_deny_q;
  assign p2_deny_o = p2_deny_q;

  bomb_slot_bank #(
    .SlotHold (SlotHold),
    .MaxSlots (MaxSlots)
  ) u_bank_p1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .grant_i (p1_put_d),
    .cap_i   (p1_cap_i),
    .full_o  (p1_full),
    .count_o (bomb_num_p1_o)
  );

  bomb_slot_bank #(
    .SlotHold (SlotHold),
    .MaxSlots (MaxSlots)
  ) u_bank_p2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .grant_i (p2_put_d),
    .cap_i   (p2_cap_i),
    .full_o  (p2_full),
    .count_o (bomb_num_p2_o)
  );

endmodule

// File: tb/tb_bomb_put_ctrl.sv
// Directed scenario bench for bomb_put_ctrl; each task checks its own expected pulses and counts.
module tb_bomb_put_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         game_run;
  logic         p1_key, p2_key;
  logic [7:0]   p1_cor, p2_cor;
  logic [2:0]   p1_cap, p2_cap;
  logic [511:0] wall_grid;
  logic [255:0] bomb_un_grid, explode;
  logic         p1_put, p2_put, p1_deny, p2_deny;
  logic [2:0]   bomb_num_p1, bomb_num_p2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bomb_put_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .game_run_i     (game_run),
    .p1_key_i       (p1_key),
    .p2_key_i       (p2_key),
    .p1_cor_i       (p1_cor),
    .p2_cor_i       (p2_cor),
    .p1_cap_i       (p1_cap),
    .p2_cap_i       (p2_cap),
    .wall_grid_i    (wall_grid),
    .bomb_un_grid_i (bomb_un_grid),
    .explode_i      (explode),
    .p1_put_o       (p1_put),
    .p2_put_o       (p2_put),
    .p1_deny_o      (p1_deny),
    .p2_deny_o      (p2_deny),
    .bomb_num_p1_o  (bomb_num_p1),
    .bomb_num_p2_o  (bomb_num_p2)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    p1_key       = 1'b0;
    p2_key       = 1'b0;
    game_run     = 1'b1;
    p1_cor       = 8'd0;
    p2_cor       = 8'd0;
    p1_cap       = 3'd4;
    p2_cap       = 3'd4;
    wall_grid    = '0;
    bomb_un_grid = '0;
    explode      = '0;
    rst_n        = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({p1_put, p1_deny, p2_put, p2_deny, bomb_num_p1, bomb_num_p2} !== 10'd0) begin
      $display("FAIL reset_outputs: got %b want 0",
               {p1_put, p1_deny, p2_put, p2_deny, bomb_num_p1, bomb_num_p2});
      bad++;
    end
    for (int i = 1; i <= 3; i++) begin
      p1_cor = 8'(i);
      p1_key = 1'b1;
      tick(1);
      if (i < 3) begin
        p1_key = 1'b0;
        tick(1);
      end
    end
    total++;
    if ({p1_put, bomb_num_p1} !== {1'b1, 3'd3}) begin
      $display("FAIL reset_pre_busy: put/num got %b/%0d want 1/3", p1_put, bomb_num_p1);
      bad++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({p1_put, p1_deny, p2_put, p2_deny, bomb_num_p1, bomb_num_p2} !== 10'd0) begin
      $display("FAIL reset_midrun: got %b want 0",
               {p1_put, p1_deny, p2_put, p2_deny, bomb_num_p1, bomb_num_p2});
      bad++;
    end
    p1_key = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    total++;
    if ({p1_put, bomb_num_p1} !== 4'd0) begin
      $display("FAIL reset_release: put/num got %b/%0d want 0/0", p1_put, bomb_num_p1);
      bad++;
    end
  endtask

  task automatic test_single_put();
    do_reset();
    p1_cap = 3'd2;
    p1_cor = 8'd17;
    p1_key = 1'b1;
    tick(1);
    total++;
    if ({p1_put, p1_deny, bomb_num_p1} !== {2'b10, 3'd1}) begin
      $display("FAIL single_put: put/deny/num got %b%b/%0d want 10/1", p1_put, p1_deny,
               bomb_num_p1);
      bad++;
    end
    for (int i = 0; i < 100; i++) begin
      tick(1);
      total++;
      if ({p1_put, p1_deny} !== 2'b00) begin
        $display("FAIL key_held cycle %0d: put/deny got %b%b want 00", i, p1_put, p1_deny);
        bad++;
      end
    end
    p1_key = 1'b0;
  endtask

  task automatic test_capacity();
    do_reset();
    p1_cap = 3'd1;
    p1_cor = 8'd40;
    p1_key = 1'b1;
    tick(1);
    total++;
    if ({p1_put, bomb_num_p1} !== {1'b1, 3'd1}) begin
      $display("FAIL cap_first: put/num got %b/%0d want 1/1", p1_put, bomb_num_p1);
      bad++;
    end
    p1_key = 1'b0;
    p1_cor = 8'd41;
    tick(9);
    p1_key = 1'b1;
    tick(1);
    total++;
    if ({p1_put, p1_deny} !== 2'b01) begin
      $display("FAIL cap_full_plus10: put/deny got %b%b want 01", p1_put, p1_deny);
      bad++;
    end
    p1_key = 1'b0;
    tick(50);
    p1_key = 1'b1;
    tick(1);
    total++;
    if ({p1_put, p1_deny, bomb_num_p1} !== {2'b10, 3'd1}) begin
      $display("FAIL cap_freed_plus61: put/deny/num got %b%b/%0d want 10/1", p1_put, p1_deny,
               bomb_num_p1);
      bad++;
    end
    p1_key = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    p1_cor = 8'd34;
    p2_cor = 8'd34;
    p1_key = 1'b1;
    p2_key = 1'b1;
    tick(1);
    total++;
    if ({p1_put, p1_deny, p2_put, p2_deny} !== 4'b1001) begin
      $display("FAIL contend_p1_prio: p1put,p1deny,p2put,p2deny got %b want 1001",
               {p1_put, p1_deny, p2_put, p2_deny});
      bad++;
    end
    p1_key = 1'b0;
    p2_key = 1'b0;
    tick(1);
    p1_cor = 8'd50;
    p2_cor = 8'd50;
    p1_key = 1'b1;
    p2_key = 1'b1;
    tick(1);
    total++;
    if ({p1_put, p1_deny, p2_put, p2_deny} !== 4'b0110) begin
      $display("FAIL contend_p2_prio: p1put,p1deny,p2put,p2deny got %b want 0110",
               {p1_put, p1_deny, p2_put, p2_deny});
      bad++;
    end
    p1_key = 1'b0;
    p2_key = 1'b0;
    tick(1);
    p1_cor = 8'd60;
    p2_cor = 8'd61;
    p1_key = 1'b1;
    p2_key = 1'b1;
    tick(1);
    total++;
    if ({p1_put, p1_deny, p2_put, p2_deny, bomb_num_p1, bomb_num_p2} !==
        {4'b1010, 3'd2, 3'd2}) begin
      $display("FAIL both_granted: pulses/num1/num2 got %b/%0d/%0d want 1010/2/2",
               {p1_put, p1_deny, p2_put, p2_deny}, bomb_num_p1, bomb_num_p2);
      bad++;
    end
    p1_key = 1'b0;
    p2_key = 1'b0;
  endtask

  task automatic test_illegal_tile();
    logic [7:0] tiles [4];
    do_reset();
    tiles = '{8'd5, 8'd6, 8'd7, 8'd8};
    wall_grid[2*5 +: 2] = 2'd2;
    wall_grid[2*6 +: 2] = 2'd1;
    bomb_un_grid[7]     = 1'b1;
    explode[8]          = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p1_cor = tiles[i];
      p1_key = 1'b1;
      tick(1);
      total++;
      if ({p1_put, p1_deny, bomb_num_p1} !== {2'b01, 3'd0}) begin
        $display("FAIL illegal_tile %0d: put/deny/num got %b%b/%0d want 01/0", tiles[i],
                 p1_put, p1_deny, bomb_num_p1);
        bad++;
      end
      p1_key = 1'b0;
      tick(1);
    end
  endtask

  task automatic test_last_grant_and_run();
    do_reset();
    p1_cor = 8'd20;
    p2_cor = 8'd20;
    p1_key = 1'b1;
    tick(1);
    total++;
    if (p1_put !== 1'b1) begin
      $display("FAIL lag_p1_grant: put got %b want 1", p1_put);
      bad++;
    end
    p1_key = 1'b0;
    p2_key = 1'b1;
    tick(1);
    total++;
    if ({p2_put, p2_deny} !== 2'b01) begin
      $display("FAIL lag_p2_same_tile: put/deny got %b%b want 01", p2_put, p2_deny);
      bad++;
    end
    p2_key = 1'b0;
    tick(1);
    p2_key = 1'b1;
    tick(1);
    total++;
    if ({p2_put, p2_deny} !== 2'b10) begin
      $display("FAIL lag_expired: put/deny got %b%b want 10", p2_put, p2_deny);
      bad++;
    end
    p2_key   = 1'b0;
    tick(1);
    game_run = 1'b0;
    p1_cor   = 8'd90;
    p2_cor   = 8'd91;
    p1_key   = 1'b1;
    p2_key   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      total++;
      if ({p1_put, p1_deny, p2_put, p2_deny} !== 4'b0000) begin
        $display("FAIL run_off cycle %0d: pulses got %b want 0000", i,
                 {p1_put, p1_deny, p2_put, p2_deny});
        bad++;
      end
    end
    p1_key   = 1'b0;
    p2_key   = 1'b0;
    game_run = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_put();
    test_capacity();
    test_contention();
    test_illegal_tile();
    test_last_grant_and_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
